switch_input: RTL and testbench
===============================

# switch_input

Operator input port for the CPU: debounces a front-panel "enter" button and, on each clean press, captures the 8 data switches into a holding register. The captured byte and a valid flag are presented to the bus/control logic, which consumes them with a one-cycle read strobe. This block is the producer-side counterpart of the output display latch: the output latch takes bytes off the bus for the operator, and this block puts operator bytes onto the bus.

## Interface
- DEBOUNCE_CYCLES, 1000: number of consecutive stable synchronized samples required to accept a press or release; must be ≥2.
- WIDTH, 8: data switch width.
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high; clears all state.
- sw  in  WIDTH  raw data switches, asynchronous to CLK.
- btn  in  1  raw enter button, asynchronous to CLK, high = pressed.
- inputEN  in  1  read strobe from control logic; consumes the held byte.
- data  out  WIDTH  captured byte; holds its value until the next capture.
- valid  out  1  captured byte not yet read.
- overrun  out  1  a capture occurred while valid was high and no read was issued in that cycle.
- busy  out  1  debounce FSM is not in IDLE.

## Operation
- sw and btn each pass through a 2-flop synchronizer, giving sw_s and btn_s. No other logic uses the raw inputs.
- Debounce FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. A counter cnt is $clog2(DEBOUNCE_CYCLES) bits wide.
  - IDLE: if btn_s=1, go to PRESS_WAIT with cnt=0.
  - PRESS_WAIT: if btn_s=0, go to IDLE. Else if cnt==DEBOUNCE_CYCLES-1, capture and go to HELD. Else increment cnt.
  - HELD: if btn_s=0, go to RELEASE_WAIT with cnt=0.
  - RELEASE_WAIT: if btn_s=1, go to HELD (bounce). Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE. Else increment cnt.
- Capture: data <= sw_s and valid <= 1. overrun <= 1 if valid was already 1 and inputEN=0 in the same cycle.
- Read (inputEN=1 with no capture in that cycle): valid <= 0 and overrun <= 0. data is unchanged.
- Read and capture in the same cycle: the capture wins. data takes the new value, valid stays 1, overrun <= 0 (the old byte counts as consumed).
- inputEN while valid=0: no effect on any output.
- One press yields exactly one capture; holding the button yields no repeats.

## Timing
- Reset values: data=0, valid=0, overrun=0, busy=0, state=IDLE, cnt=0, synchronizers=0.
- Reset asserted mid-debounce or while valid=1 drops everything immediately (asynchronously). After release the FSM starts in IDLE. A button still held at reset release is treated as a new press.
- Latency: let edge k be the first rising edge at which raw btn is sampled high and stable. State becomes PRESS_WAIT at edge k+2, capture occurs at edge k+2+DEBOUNCE_CYCLES, and valid is high in the following cycle.
- sw must be stable for 2 cycles before the capture edge; the captured value is sw_s at that edge.
- Read effect is visible in the cycle after the inputEN edge.
- busy = (state != IDLE), registered state only.

## Structure
- Shared CPU package holds:
  - typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} debounce_state_t.
  - Default data width constant (8), shared with the display and bus logic.
- One sub-module: synchronizer (parameter WIDTH; 2-flop, async active-high reset to 0), instantiated for sw and for btn.
- FSM, counter and holding register live in switch_input.

## Test plan
Use DEBOUNCE_CYCLES=4 throughout.
- Reset behaviour: assert RST mid-PRESS_WAIT with valid=1 -> all outputs 0 immediately. Release RST with btn low -> IDLE, no capture.
- Clean press: sw=8'hA5, btn raised and held -> valid=1 and data=8'hA5 exactly 6 edges after btn is first sampled; no second capture while held.
- Bounce rejection: btn high 2 cycles, low 1, high 2, low -> no capture, valid stays 0, busy returns to 0. Release bounce inside RELEASE_WAIT returns to HELD with no capture.
- Read handshake: after capture of 8'h3C, pulse inputEN one cycle -> valid=0 next cycle, data stays 8'h3C. A second inputEN has no effect.
- Overrun: capture 8'h11, then press again with sw=8'h22 and no read -> data=8'h22, valid=1, overrun=1. inputEN -> valid=0, overrun=0.
- Simultaneous read and capture: inputEN on the capture edge for 8'h77 while 8'h11 is pending -> data=8'h77, valid=1, overrun=0.

Source files
------------

// File: rtl/switch_input_pkg.sv
// Shared CPU package: debounce FSM state encoding and the default data width
// used by the operator input port, the display latch and the bus logic.
package switch_input_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } debounce_state_t;

  localparam int DATA_WIDTH = 8;

endpackage

// File: rtl/switch_input_sync.sv
// Two-flop synchronizer for asynchronous operator inputs; clears to zero on reset.
module switch_input_sync #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture of the raw input to settle metastability.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/switch_input.sv
// Operator input port: debounces the enter button and, once per clean press,
// captures the synchronized data switches into a holding register that the
// control logic drains with a one-cycle read strobe.
module switch_input
  import switch_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int WIDTH           = DATA_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn,
  input  logic             inputEN,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun,
  output logic             busy
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] w_sw_s;
  logic [0:0]       w_btn_s;

  debounce_state_t  r_state;
  debounce_state_t  w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_capture;
  logic             w_busy_nxt;

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             r_busy;

  switch_input_sync #(.WIDTH(WIDTH)) u_sync_sw (
    .i_clk (CLK),
    .i_rst (RST),
    .i_d   (sw),
    .o_q   (w_sw_s)
  );

  switch_input_sync #(.WIDTH(1)) u_sync_btn (
    .i_clk (CLK),
    .i_rst (RST),
    .i_d   (btn),
    .o_q   (w_btn_s)
  );

  // Debounce state and stability counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: a press or release is accepted only after the
  // synchronized button holds its level for DEBOUNCE_CYCLES further samples.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_btn_s[0]) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      PRESS_WAIT: begin
        if (!w_btn_s[0]) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!w_btn_s[0]) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = HELD;
        end
      end
      RELEASE_WAIT: begin
        if (w_btn_s[0]) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // FSM outputs: capture strobe on the accepting edge, busy tracks the next state.
  always_comb begin
    w_capture  = (r_state == PRESS_WAIT) && w_btn_s[0] && (r_cnt == CNT_LAST);
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // Busy flag registered so it always equals (state != IDLE).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Holding register: a capture outranks a read; a read only clears pending state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_capture) begin
      r_data    <= w_sw_s;
      r_valid   <= 1'b1;
      r_overrun <= r_valid & ~inputEN;
    end else if (inputEN && r_valid) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid   <= r_valid;
      r_overrun <= r_overrun;
    end
  end

  assign data    = r_data;
  assign valid   = r_valid;
  assign overrun = r_overrun;
  assign busy    = r_busy;

endmodule

// File: tb/tb_switch_input.sv
// Self-checking bench for switch_input with DEBOUNCE_CYCLES=4: directed test
// plan followed by randomized button/switch/read activity, all compared
// against a run-length based reference model.
module tb_switch_input;

  localparam int D = 4;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] sw;
  logic         btn;
  logic         inputEN;
  logic [W-1:0] data;
  logic         valid;
  logic         overrun;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: raw inputs reach the debouncer two edges late; a press
  // is taken after D+1 consecutive high samples, a release after D+1 lows.
  bit           q_b[$];
  logic [W-1:0] q_s[$];
  int           hi_run;
  int           lo_run;
  bit           pressed;
  logic [W-1:0] m_data;
  bit           m_valid;
  bit           m_ovr;
  bit           m_busy;

  switch_input #(.DEBOUNCE_CYCLES(D), .WIDTH(W)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .sw      (sw),
    .btn     (btn),
    .inputEN (inputEN),
    .data    (data),
    .valid   (valid),
    .overrun (overrun),
    .busy    (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_b = '{1'b0, 1'b0};
    q_s = '{8'h00, 8'h00};
    hi_run = 0; lo_run = 0; pressed = 1'b0;
    m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
  endtask

  task automatic model_edge();
    bit           b_s;
    logic [W-1:0] s_s;
    bit           cap;
    b_s = q_b.pop_front();
    s_s = q_s.pop_front();
    q_b.push_back(btn);
    q_s.push_back(sw);
    cap = 1'b0;
    if (!pressed) begin
      hi_run = b_s ? hi_run + 1 : 0;
      if (hi_run == D + 1) begin
        cap = 1'b1; pressed = 1'b1; hi_run = 0; lo_run = 0;
      end
    end else begin
      lo_run = b_s ? 0 : lo_run + 1;
      if (lo_run == D + 1) begin
        pressed = 1'b0; lo_run = 0; hi_run = 0;
      end
    end
    if (cap) begin
      m_ovr   = m_valid && !inputEN;
      m_data  = s_s;
      m_valid = 1'b1;
    end else if (inputEN && m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    m_busy = pressed || (hi_run > 0);
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check("data",    32'(data),    32'(m_data));
    check("valid",   32'(valid),   32'(m_valid));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("busy",    32'(busy),    32'(m_busy));
  endtask

  task automatic assert_reset();
    RST = 1'b1;
    model_reset();
    #1;
    check("rst_data",    32'(data),    32'h0);
    check("rst_valid",   32'(valid),   32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic press_release(input logic [W-1:0] v);
    sw = v;
    repeat (3) step();
    btn = 1'b1;
    repeat (9) step();
    btn = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    RST = 1'b1; sw = 8'h00; btn = 1'b0; inputEN = 1'b0;
    assert_reset();
    repeat (3) step();

    // Clean press: capture exactly 6 edges after btn is first sampled.
    sw = 8'hA5;
    repeat (3) step();
    btn = 1'b1;
    repeat (6) step();
    check("clean_early_valid", 32'(valid), 32'h0);
    step();
    check("clean_valid", 32'(valid), 32'h1);
    check("clean_data",  32'(data),  32'hA5);
    repeat (12) step();
    check("held_no_repeat", 32'(overrun), 32'h0);
    btn = 1'b0;
    repeat (8) step();
    check("clean_idle", 32'(busy), 32'h0);
    inputEN = 1'b1; step(); inputEN = 1'b0; step();

    // Press bounce: 2 high, 1 low, 2 high, then low.
    btn = 1'b1; repeat (2) step();
    btn = 1'b0; step();
    btn = 1'b1; repeat (2) step();
    btn = 1'b0; repeat (10) step();
    check("bounce_valid", 32'(valid), 32'h0);
    check("bounce_busy",  32'(busy),  32'h0);

    // Release bounce inside RELEASE_WAIT returns to HELD without capturing.
    sw = 8'h3C; repeat (3) step();
    btn = 1'b1; repeat (9) step();
    btn = 1'b0; repeat (2) step();
    btn = 1'b1; repeat (2) step();
    check("relbounce_busy", 32'(busy), 32'h1);
    btn = 1'b0; repeat (8) step();
    check("relbounce_data",    32'(data),    32'h3C);
    check("relbounce_overrun", 32'(overrun), 32'h0);

    // Read handshake.
    inputEN = 1'b1; step(); inputEN = 1'b0;
    check("read_valid", 32'(valid), 32'h0);
    check("read_data",  32'(data),  32'h3C);
    inputEN = 1'b1; step(); inputEN = 1'b0; step();
    check("read2_valid", 32'(valid), 32'h0);
    check("read2_data",  32'(data),  32'h3C);

    // Overrun.
    press_release(8'h11);
    press_release(8'h22);
    check("ovr_data",    32'(data),    32'h22);
    check("ovr_valid",   32'(valid),   32'h1);
    check("ovr_overrun", 32'(overrun), 32'h1);
    inputEN = 1'b1; step(); inputEN = 1'b0;
    check("ovr_read_valid",   32'(valid),   32'h0);
    check("ovr_read_overrun", 32'(overrun), 32'h0);

    // Simultaneous read and capture.
    press_release(8'h11);
    sw = 8'h77; repeat (3) step();
    btn = 1'b1; repeat (6) step();
    inputEN = 1'b1; step(); inputEN = 1'b0;
    check("simul_data",    32'(data),    32'h77);
    check("simul_valid",   32'(valid),   32'h1);
    check("simul_overrun", 32'(overrun), 32'h0);
    btn = 1'b0; repeat (8) step();

    // Reset mid-PRESS_WAIT while a byte is pending.
    sw = 8'h55; btn = 1'b1; repeat (4) step();
    check("pre_rst_busy", 32'(busy), 32'h1);
    btn = 1'b0;
    assert_reset();
    repeat (8) step();
    check("post_rst_valid", 32'(valid), 32'h0);
    check("post_rst_busy",  32'(busy),  32'h0);

    // Button held through reset release counts as a new press.
    sw = 8'h9A; btn = 1'b1;
    assert_reset();
    repeat (7) step();
    check("held_rst_valid", 32'(valid), 32'h1);
    check("held_rst_data",  32'(data),  32'h9A);
    btn = 1'b0; repeat (8) step();

    // Randomized activity against the model.
    for (int seg = 0; seg < 60; seg++) begin
      int len;
      btn = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      if ($urandom_range(0, 2) == 0) sw = 8'($urandom);
      for (int c = 0; c < len; c++) begin
        inputEN = ($urandom_range(0, 3) == 0);
        step();
      end
    end
    inputEN = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
